// File: rtl/seg_arb_pkg.sv
// Shared definitions for the segment display arbiter: FSM encoding, default
// sizes and the dwell counter load value helper.
package seg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int DWELL_DEF  = 5000;
  localparam int CNT_W      = 16;

  // The counter counts DWELL-1 down to 0, so the owner keeps DWELL cycles.
  function automatic logic [CNT_W-1:0] dwell_load(input int dwell);
    return (dwell == 0) ? '0 : CNT_W'(dwell - 1);
  endfunction

endpackage

// File: rtl/seg_dwell_timer.sv
// Dwell counter: load has priority, otherwise decrement, saturating at zero.
module seg_dwell_timer
  import seg_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/seg_display_arbiter.sv
// Two-requester round-robin arbiter for a single display write port; a granted
// requester holds the display for DWELL cycles and may rewrite during that time.
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DWELL  = DWELL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_stb,
  input  logic [DATA_W-1:0] req0_dat,
  output logic              req0_ack,
  input  logic              req1_stb,
  input  logic [DATA_W-1:0] req1_dat,
  output logic              req1_ack,
  output logic              disp_we,
  output logic [DATA_W-1:0] disp_dat,
  output logic              owner,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LOAD_VAL = dwell_load(DWELL);
  localparam bit               NO_DWELL = (DWELL == 0);

  state_t            state_q;
  logic              disp_we_q;
  logic [DATA_W-1:0] disp_dat_q;
  logic              ack0_q, ack1_q;
  logic              owner_q, last_q, busy_q;

  logic start_write, grant_sel;
  logic tmr_load, tmr_dec, tmr_zero;

  // In DWELL only the current owner may start a write; the other side waits for IDLE.
  always_comb begin
    start_write = 1'b0;
    grant_sel   = owner_q;
    case (state_q)
      ST_IDLE: begin
        start_write = req0_stb | req1_stb;
        grant_sel   = (req0_stb && req1_stb) ? ~last_q : req1_stb;
      end
      ST_DWELL: begin
        start_write = owner_q ? req1_stb : req0_stb;
      end
      default: ;
    endcase
  end

  assign tmr_load = (state_q == ST_WRITE);
  assign tmr_dec  = (state_q == ST_DWELL) && !start_write;

  seg_dwell_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (LOAD_VAL),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      disp_we_q  <= 1'b0;
      disp_dat_q <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      disp_we_q <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      if (start_write) begin
        state_q    <= ST_WRITE;
        disp_we_q  <= 1'b1;
        disp_dat_q <= grant_sel ? req1_dat : req0_dat;
        ack0_q     <= ~grant_sel;
        ack1_q     <= grant_sel;
        owner_q    <= grant_sel;
        last_q     <= grant_sel;
        busy_q     <= 1'b1;
      end else begin
        case (state_q)
          ST_WRITE: begin
            state_q <= NO_DWELL ? ST_IDLE : ST_DWELL;
            busy_q  <= !NO_DWELL;
          end
          ST_DWELL: begin
            if (tmr_zero) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign req0_ack = ack0_q;
  assign req1_ack = ack1_q;
  assign disp_we  = disp_we_q;
  assign disp_dat = disp_dat_q;
  assign owner    = owner_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench: a DWELL=4 arbiter checked through an expected-write
// queue, plus a DWELL=0 arbiter checked against a per-cycle pattern table.
module tb_seg_display_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_stb, req1_stb, req0_ack, req1_ack;
  logic [15:0] req0_dat, req1_dat, disp_dat;
  logic        disp_we, owner, busy;

  logic        z_req0_stb, z_req1_stb, z_req0_ack, z_req1_ack;
  logic [15:0] z_req0_dat, z_req1_dat, z_disp_dat;
  logic        z_disp_we, z_owner, z_busy;

  always #5 clk = ~clk;

  seg_display_arbiter #(.DATA_W(16), .DWELL(4)) dut (
    .clk(clk), .rst(rst),
    .req0_stb(req0_stb), .req0_dat(req0_dat), .req0_ack(req0_ack),
    .req1_stb(req1_stb), .req1_dat(req1_dat), .req1_ack(req1_ack),
    .disp_we(disp_we), .disp_dat(disp_dat), .owner(owner), .busy(busy)
  );

  seg_display_arbiter #(.DATA_W(16), .DWELL(0)) dut_z (
    .clk(clk), .rst(rst),
    .req0_stb(z_req0_stb), .req0_dat(z_req0_dat), .req0_ack(z_req0_ack),
    .req1_stb(z_req1_stb), .req1_dat(z_req1_dat), .req1_ack(z_req1_ack),
    .disp_we(z_disp_we), .disp_dat(z_disp_dat), .owner(z_owner), .busy(z_busy)
  );

  typedef struct { logic [15:0] dat; logic own; } exp_t;
  typedef struct { bit s0; bit s1; logic [15:0] d0; logic [15:0] d1; bit first; } row_t;
  typedef struct { bit a0; bit a1; bit bz; logic [15:0] dat; } zrow_t;

  exp_t  exp_q[$];
  int    wr_cyc[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    start;
  row_t  rows[8];
  zrow_t zrows[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic own, input logic [15:0] dat);
    exp_t e;
    e.own = own;
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  // Scoreboard for the DWELL=4 instance; requesters drop stb once acked.
  task automatic monitor();
    exp_t e;
    chk("ack_outside_write", 32'(((req0_ack || req1_ack) && !disp_we) || (req0_ack && req1_ack)), 0);
    if (disp_we) begin
      $display("write cyc=%0d owner=%0d dat=%h ack0=%0b ack1=%0b", cyc, owner, disp_dat, req0_ack, req1_ack);
      wr_cyc.push_back(cyc);
      chk("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_dat", disp_dat, e.dat);
        chk("wr_owner", owner, e.own);
        chk("wr_ack0", req0_ack, !e.own);
        chk("wr_ack1", req1_ack, e.own);
      end
      if (req0_ack) req0_stb = 1'b0;
      if (req1_ack) req1_stb = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      step();
      n++;
    end
    chk("drain_in_time", 32'(exp_q.size() == 0 && !busy), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    chk("rst_we", disp_we, 0);
    chk("rst_dat", disp_dat, 0);
    chk("rst_acks", {req0_ack, req1_ack}, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_z_busy", z_busy, 0);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req0_stb = 0; req1_stb = 0; req0_dat = '0; req1_dat = '0;
    z_req0_stb = 0; z_req1_stb = 0; z_req0_dat = '0; z_req1_dat = '0;

    // IDLE arbitration vectors, applied back to back after a reset (last=1).
    rows[0] = '{1, 1, 16'hAAAA, 16'h5555, 0};
    rows[1] = '{1, 1, 16'h1111, 16'h2222, 0};
    rows[2] = '{0, 1, 16'h0000, 16'h3333, 1};
    rows[3] = '{1, 1, 16'h4444, 16'h5555, 0};
    rows[4] = '{1, 0, 16'h6666, 16'h0000, 0};
    rows[5] = '{1, 1, 16'h7777, 16'h8888, 1};
    rows[6] = '{0, 1, 16'h0000, 16'h9999, 1};
    rows[7] = '{1, 0, 16'hABCD, 16'h0000, 0};

    zrows[0] = '{1, 0, 1, 16'h0101};
    zrows[1] = '{0, 0, 0, 16'h0101};
    zrows[2] = '{0, 1, 1, 16'h0202};
    zrows[3] = '{0, 0, 0, 16'h0202};
    zrows[4] = '{1, 0, 1, 16'h0101};
    zrows[5] = '{0, 0, 0, 16'h0101};

    do_reset();

    // Single request: one-cycle latency, busy for WRITE plus four DWELL cycles.
    wr_cyc.delete();
    start = cyc;
    req0_dat = 16'h1234; req0_stb = 1'b1;
    push_exp(0, 16'h1234);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("busy_c%0d", i), busy, 32'(i <= 5));
    end
    chk("s1_writes", wr_cyc.size(), 1);
    if (wr_cyc.size() == 1) chk("s1_lat", wr_cyc[0] - start, 1);

    do_reset();

    foreach (rows[r]) begin
      wr_cyc.delete();
      start = cyc;
      req0_dat = rows[r].d0; req1_dat = rows[r].d1;
      req0_stb = rows[r].s0; req1_stb = rows[r].s1;
      if (rows[r].s0 && rows[r].s1) begin
        push_exp(rows[r].first, rows[r].first ? rows[r].d1 : rows[r].d0);
        push_exp(!rows[r].first, rows[r].first ? rows[r].d0 : rows[r].d1);
      end else begin
        push_exp(rows[r].s1, rows[r].s1 ? rows[r].d1 : rows[r].d0);
      end
      drain(40);
      chk($sformatf("row%0d_writes", r), wr_cyc.size(), (rows[r].s0 && rows[r].s1) ? 2 : 1);
      if (wr_cyc.size() >= 1) chk($sformatf("row%0d_lat1", r), wr_cyc[0] - start, 1);
      if (wr_cyc.size() >= 2) chk($sformatf("row%0d_lat2", r), wr_cyc[1] - start, 7);
    end

    // Owner rewrite in the second DWELL cycle restarts the dwell; req1 waits.
    wr_cyc.delete();
    start = cyc;
    req0_dat = 16'hC0DE; req0_stb = 1'b1;
    push_exp(0, 16'hC0DE);
    step();
    req1_dat = 16'h5A5A; req1_stb = 1'b1;
    step();
    step();
    req0_dat = 16'h0F0F; req0_stb = 1'b1;
    push_exp(0, 16'h0F0F);
    push_exp(1, 16'h5A5A);
    drain(40);
    chk("rw_writes", wr_cyc.size(), 3);
    if (wr_cyc.size() == 3) begin
      chk("rw_lat_rewrite", wr_cyc[1] - start, 4);
      chk("rw_lat_req1", wr_cyc[2] - start, 10);
    end

    // Asynchronous reset in DWELL, then the still-pending req1 is served.
    wr_cyc.delete();
    req0_dat = 16'hBEEF; req0_stb = 1'b1;
    push_exp(0, 16'hBEEF);
    step();
    req1_dat = 16'h7777; req1_stb = 1'b1;
    step();
    step();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #2;
    chk("arst_we", disp_we, 0);
    chk("arst_acks", {req0_ack, req1_ack}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_dat", disp_dat, 0);
    chk("arst_owner", owner, 0);
    step();
    rst = 1'b0;
    wr_cyc.delete();
    start = cyc;
    push_exp(1, 16'h7777);
    drain(40);
    chk("post_rst_writes", wr_cyc.size(), 1);
    if (wr_cyc.size() == 1) chk("post_rst_lat", wr_cyc[0] - start, 1);

    // DWELL=0: both strobes held, grants alternate every two cycles.
    begin
      logic prev_busy;
      prev_busy = z_busy;
      z_req0_dat = 16'h0101; z_req1_dat = 16'h0202;
      z_req0_stb = 1'b1; z_req1_stb = 1'b1;
      foreach (zrows[i]) begin
        step();
        $display("z cyc=%0d ack0=%0b ack1=%0b busy=%0b dat=%h", cyc, z_req0_ack, z_req1_ack, z_busy, z_disp_dat);
        chk($sformatf("z%0d_ack0", i), z_req0_ack, zrows[i].a0);
        chk($sformatf("z%0d_ack1", i), z_req1_ack, zrows[i].a1);
        chk($sformatf("z%0d_busy", i), z_busy, zrows[i].bz);
        chk($sformatf("z%0d_we", i), z_disp_we, zrows[i].a0 | zrows[i].a1);
        chk($sformatf("z%0d_dat", i), z_disp_dat, zrows[i].dat);
        chk($sformatf("z%0d_busy_run", i), 32'(z_busy && prev_busy), 0);
        prev_busy = z_busy;
      end
      z_req0_stb = 1'b0; z_req1_stb = 1'b0;
      step();
      step();
      chk("z_idle_busy", z_busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 Parameter DATA_W, 16, width of display data word.
REQ-002 Parameter DWELL, 5000, minimum cycles a granted requester holds the display after a write (0..65535).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req0_stb  in  1  requester 0 write strobe; held high with req0_dat stable until req0_ack.
REQ-006 req0_dat  in  DATA_W  requester 0 display word.
REQ-007 req0_ack  out  1  one-cycle acknowledge to requester 0.
REQ-008 req1_stb, req1_dat, req1_ack: same as REQ-005..007 for requester 1.
REQ-009 disp_we  out  1  one-cycle write enable to display driver WE_I.
REQ-010 disp_dat  out  DATA_W  word to display driver DAT_I; holds last written value.
REQ-011 owner  out  1  index of requester that last wrote the display.
REQ-012 busy  out  1  high whenever FSM not in IDLE.

Function
REQ-013 FSM states IDLE, WRITE, DWELL; all outputs registered.
REQ-014 IDLE: no stb -> stay; one stb -> capture that requester's data, set owner, go WRITE.
REQ-015 IDLE, both stb: grant requester not served last (round-robin pointer last); pointer updates on every grant.
REQ-016 WRITE lasts exactly one cycle: disp_we=1, disp_dat=captured word, ack of granted requester=1, other ack=0.
REQ-017 Latency: stb sampled high in IDLE at cycle N -> disp_we and ack in cycle N+1.
REQ-018 WRITE exit: DWELL=0 -> IDLE; else load dwell counter with DWELL-1, go DWELL.
REQ-019 DWELL: counter !=0 -> decrement; counter==0 -> IDLE next cycle.
REQ-020 DWELL, current owner's stb high -> capture, go WRITE, counter reloads there (rewrite allowed; takes priority over expiry in same cycle).
REQ-021 DWELL, non-owner stb: ignored, no ack, stays pending; arbitrated in IDLE.
REQ-022 stb still high in cycle after ack is a new request.
REQ-023 stb dropped after capture (protocol violation): write and ack still complete.
REQ-024 disp_we, req0_ack, req1_ack never high outside WRITE; at most one ack high per cycle.
REQ-025 Counter width 16 bits, unsigned, no wrap (decrement gated at 0).

Reset
REQ-026 rst high clears immediately, clock-independent: state IDLE, disp_we 0, disp_dat 0, acks 0, owner 0, busy 0, counter 0, last=1 (requester 0 wins first tie).
REQ-027 Reset mid-WRITE/DWELL aborts without ack; pending requester must keep stb high and is arbitrated fresh after release.
REQ-028 First rising edge with rst low performs normal IDLE evaluation.

Structure
REQ-029 Shared package seg_arb_pkg holds state encoding (IDLE=2'd0, WRITE=2'd1, DWELL=2'd2), DATA_W and DWELL defaults.
REQ-030 Dwell counter as sub-module seg_dwell_timer (load, decrement-to-zero, zero flag); arbitration/FSM in top.
REQ-031 disp_we/disp_dat connect one-to-one to display driver WE_I/DAT_I; no other write path to display.

Verification (bench DWELL=4)
REQ-032 Reset release, req0_stb=1 dat 0x1234 at N -> N+1 disp_we=1, disp_dat=0x1234, req0_ack=1, owner=0; busy high N+1..N+5, low N+6.
REQ-033 Both stb at N (0xAAAA/0x5555) after reset -> req0 acked N+1; req1 acked N+7 with disp_dat=0x5555, owner=1.
REQ-034 Continuing, both stb again -> req0 granted (round-robin), req1 waits full dwell.
REQ-035 req0 writes, req0 stb 0x0F0F in 2nd DWELL cycle with req1 pending -> disp_we next cycle with 0x0F0F, counter reloaded to 3, req1 unacked until 4 DWELL cycles + 1 IDLE later.
REQ-036 rst asserted mid-DWELL, no clock edge -> disp_we, acks, busy, disp_dat 0 at once; after release req1 (still strobing) acked 2nd edge.
REQ-037 DWELL=0 build, both stb held continuously -> acks alternate req0, req1, req0 every 2 cycles, busy never more than 1 cycle.
